demux_9_stream: RTL and testbench
=================================

// Module: demux_9_stream
// PURPOSE
//   1-to-9 stream demultiplexer: the distribution-side counterpart of the 9:1 selector mux.
//   Routes each accepted input beat to one of nine output channels by a 4-bit select.
//   Each channel has a one-entry registered holding slot with valid/ready handshake.
//   Beats with an out-of-range select (9..15) are consumed and counted, never delivered.
// PARAMETERS
//   DW     1  data width of every channel
//   CNT_W  8  width of the saturating drop counter
// PORTS
//   clk        in   1     single clock, all state rising-edge
//   rst        in   1     asynchronous, active-high reset
//   in_valid   in   1     input beat valid
//   in_ready   out  1     input beat accepted this cycle when in_valid & in_ready
//   in_data    in   DW    input payload
//   in_sel     in   4     destination channel 0..8; 9..15 = invalid
//   out_valid  out  9     per-channel valid; bit k = channel k
//   out_ready  in   9     per-channel downstream ready
//   out_data   out  9*DW  channel k at [k*DW +: DW]
//   drop_cnt   out  CNT_W count of beats dropped for invalid sel, saturating
//   drop_pulse out  1     registered 1-cycle pulse per dropped beat
// BEHAVIOUR
//   Reset (async assert, sync deassert at the flop level): out_valid=0, out_data=0,
//     drop_cnt=0, drop_pulse=0. Any beat held in a slot at reset is discarded.
//   in_ready (combinational):
//     - in_sel<=8: in_ready = !out_valid[in_sel] | out_ready[in_sel].
//     - in_sel>=9: in_ready = 1.
//     - in_ready may depend on in_sel/out_ready; it never depends on in_data.
//   acc = in_valid & in_ready.
//   Channel k slot, every cycle:
//     - acc & in_sel==k: out_data[k] <= in_data; out_valid[k] <= 1.
//       Load wins over a simultaneous drain, giving full throughput.
//     - else if out_valid[k] & out_ready[k]: out_valid[k] <= 0; out_data[k] holds.
//     - else: hold.
//   Latency: accepted beat visible on out_* the next cycle. One beat/cycle total.
//   Stall: a valid channel with out_ready=0 holds data/valid stable. It blocks only beats
//     targeting it; other channels and drops proceed.
//   Ordering: per-channel order preserved (single slot). No cross-channel ordering.
//   Drop: acc & in_sel>=9 -> no slot change; drop_pulse <= 1 next cycle; drop_cnt += 1.
//     drop_cnt saturates at 2^CNT_W-1 and holds there until reset.
//   in_valid=0: no loads and no drops; in_sel is ignored.
//   out_ready[k] while out_valid[k]=0 is ignored.
//   No internal state machine beyond the nine slot-valid flags and the counter.
// TESTING
//   1 Reset: assert rst mid-stream with slots 2 and 5 full -> same cycle out_valid=0,
//     drop_cnt=0; after release all in_ready=1 for any sel.
//   2 Routing: DW=8, sel=0..8 back-to-back, data=8'hA0+sel, all out_ready=1 ->
//     out_valid[k] high exactly 1 cycle after its beat with data A0+k; one beat/cycle sustained.
//   3 Backpressure: out_ready[3]=0, send 2 beats to ch3 (11,22) ->
//     first held as 11; second stalls with in_ready=0.
//     Raise out_ready[3] -> 11 drains, 22 loads the same cycle, then 22 appears.
//   4 Isolation: ch3 stalled full; send beat to ch4 -> accepted, out_data[4] correct,
//     ch3 unchanged.
//   5 Invalid sel: sel=9,12,15 with in_valid=1 -> in_ready=1, no out_valid change;
//     drop_pulse x3; drop_cnt=3.
//   6 Saturation: CNT_W=2, 5 invalid beats -> drop_cnt 1,2,3,3,3; drop_pulse still fires on each.

Source files
------------

// File: rtl/demux_9_stream.sv
// 1-to-9 stream demultiplexer with one registered holding slot per channel.
// Out-of-range selects (9..15) are consumed, counted and never delivered.

// One-entry holding slot for a single output channel.
module demux_9_stream_slot #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] din,
  input  logic          ready,
  output logic          valid,
  output logic [DW-1:0] data
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;

  // Load wins over drain so a full slot can be refilled every cycle.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = din;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  // Slot state; reset discards any held beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

module demux_9_stream #(
  parameter int DW    = 1,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  input  logic [3:0]        in_sel,
  output logic [8:0]        out_valid,
  input  logic [8:0]        out_ready,
  output logic [9*DW-1:0]   out_data,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              drop_pulse
);

  localparam int NUM_CH = 9;

  logic              sel_ok;
  logic              acc;
  logic [15:0]       vld_ext, rdy_ext;
  logic [NUM_CH-1:0] load;
  logic              drop;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pulse_q, pulse_d;

  // Zero-extend to 16 entries so any 4-bit select indexes in range;
  // the upper entries are never used because sel_ok gates them out.
  assign vld_ext = {7'b0, out_valid};
  assign rdy_ext = {7'b0, out_ready};

  // Ready depends only on the select and the addressed slot, never on data.
  always_comb begin
    sel_ok   = (in_sel <= 4'd8);
    in_ready = 1'b1;
    if (sel_ok) in_ready = !vld_ext[in_sel] || rdy_ext[in_sel];
  end

  assign acc  = in_valid && in_ready;
  assign drop = acc && !sel_ok;

  // One-hot load strobe per channel.
  always_comb begin
    load = '0;
    for (int k = 0; k < NUM_CH; k++) load[k] = acc && (in_sel == 4'(k));
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    demux_9_stream_slot #(.DW(DW)) u_slot (
      .clk   (clk),
      .rst   (rst),
      .load  (load[k]),
      .din   (in_data),
      .ready (out_ready[k]),
      .valid (out_valid[k]),
      .data  (out_data[k*DW +: DW])
    );
  end

  // Saturating drop counter and per-drop pulse.
  always_comb begin
    pulse_d = drop;
    cnt_d   = cnt_q;
    if (drop && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  // Drop bookkeeping registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign drop_cnt   = cnt_q;
  assign drop_pulse = pulse_q;

endmodule

// File: tb/tb_demux_9_stream.sv
// Randomized + directed bench for demux_9_stream against a queue-free slot model.
// Two DUTs share stimulus: default counter width and a 2-bit counter for saturation.
module tb_demux_9_stream;

  localparam int DW = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [DW-1:0] in_data;
  logic [3:0]   in_sel;
  logic [8:0]   out_ready;

  logic         in_ready, in_ready_s;
  logic [8:0]   out_valid, out_valid_s;
  logic [9*DW-1:0] out_data, out_data_s;
  logic [7:0]   drop_cnt;
  logic [1:0]   drop_cnt_s;
  logic         drop_pulse, drop_pulse_s;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state: channel contents and total drops as plain arrays/ints.
  bit          m_vld [9];
  logic [7:0]  m_dat [9];
  int          m_drops;
  bit          m_pulse;

  always #5 clk = ~clk;

  demux_9_stream #(.DW(DW), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .drop_cnt(drop_cnt),
    .drop_pulse(drop_pulse)
  );

  demux_9_stream #(.DW(DW), .CNT_W(2)) u_dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid_s),
    .out_ready(out_ready), .out_data(out_data_s), .drop_cnt(drop_cnt_s),
    .drop_pulse(drop_pulse_s)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_ready(input logic [3:0] sel, input logic [8:0] rdy);
    if (sel >= 4'd9) return 1'b1;
    return !m_vld[sel] || rdy[sel];
  endfunction

  function automatic logic [8:0] model_vld();
    logic [8:0] v;
    for (int k = 0; k < 9; k++) v[k] = m_vld[k];
    return v;
  endfunction

  function automatic logic [9*DW-1:0] model_dat();
    logic [9*DW-1:0] d;
    for (int k = 0; k < 9; k++) d[k*DW +: DW] = m_dat[k];
    return d;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 9; k++) begin
      m_vld[k] = 1'b0;
      m_dat[k] = '0;
    end
    m_drops = 0;
    m_pulse = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    int sat8, sat2;
    sat8 = (m_drops > 255) ? 255 : m_drops;
    sat2 = (m_drops > 3) ? 3 : m_drops;
    chk({tag, ".out_valid"}, out_valid, model_vld());
    chk({tag, ".out_data"}, out_data, model_dat());
    chk({tag, ".drop_cnt"}, drop_cnt, sat8);
    chk({tag, ".drop_pulse"}, drop_pulse, m_pulse);
    chk({tag, ".sat_cnt"}, drop_cnt_s, sat2);
    chk({tag, ".sat_valid"}, out_valid_s, model_vld());
    chk({tag, ".sat_pulse"}, drop_pulse_s, m_pulse);
  endtask

  // One clock: drive at negedge, check combinational ready, advance model, check outputs.
  task automatic cycle(input string tag, input bit v, input logic [3:0] sel,
                       input logic [7:0] dat, input logic [8:0] rdy);
    bit exp_rdy, acc;
    @(negedge clk);
    in_valid = v; in_sel = sel; in_data = dat; out_ready = rdy;
    #1;
    exp_rdy = model_ready(sel, rdy);
    chk({tag, ".in_ready"}, in_ready, exp_rdy);
    chk({tag, ".in_ready_s"}, in_ready_s, exp_rdy);
    acc = v && exp_rdy;
    @(posedge clk);
    m_pulse = acc && (sel >= 4'd9);
    if (m_pulse) m_drops++;
    for (int k = 0; k < 9; k++) begin
      if (acc && sel == 4'(k)) begin
        m_vld[k] = 1'b1;
        m_dat[k] = dat;
      end else if (m_vld[k] && rdy[k]) begin
        m_vld[k] = 1'b0;
      end
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    model_clear();
    chk("rst.out_valid", out_valid, 9'h0);
    chk("rst.drop_cnt", drop_cnt, 8'h0);
    chk("rst.out_data", out_data, '0);
    chk("rst.drop_pulse", drop_pulse, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = '0;
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_outputs("init");

    // Reset mid-stream with slots 2 and 5 full and a nonzero drop count.
    cycle("pre", 1'b1, 4'd2, 8'h22, 9'h0);
    cycle("pre", 1'b1, 4'd5, 8'h55, 9'h0);
    cycle("pre", 1'b1, 4'd10, 8'h00, 9'h0);
    chk("pre.full25", out_valid, 9'h024);
    do_reset();
    for (int s = 0; s < 16; s++) begin
      in_sel = 4'(s); in_valid = 1'b0; out_ready = '0;
      #1;
      chk("post_rst.in_ready", in_ready, 1'b1);
    end

    // Routing: back-to-back sel 0..8, sustained one beat per cycle.
    for (int s = 0; s < 9; s++) begin
      cycle("route", 1'b1, 4'(s), 8'hA0 + 8'(s), 9'h1FF);
      chk("route.onehot", out_valid, 9'(1) << s);
      chk("route.data", out_data[s*DW +: DW], 8'hA0 + 8'(s));
    end
    cycle("route.idle", 1'b0, 4'd0, 8'h00, 9'h1FF);

    // Backpressure on ch3, with ch4 isolation while ch3 is stalled.
    cycle("bp", 1'b1, 4'd3, 8'h11, 9'h1F7);
    cycle("bp", 1'b1, 4'd3, 8'h22, 9'h1F7);
    chk("bp.stall_ready", in_ready, 1'b0);
    chk("bp.held", out_data[3*DW +: DW], 8'h11);
    cycle("iso", 1'b1, 4'd4, 8'h44, 9'h1E7);
    chk("iso.ch4", out_data[4*DW +: DW], 8'h44);
    chk("iso.ch3", out_data[3*DW +: DW], 8'h11);
    cycle("bp.release", 1'b1, 4'd3, 8'h22, 9'h1FF);
    chk("bp.next", out_data[3*DW +: DW], 8'h22);
    cycle("bp.drain", 1'b0, 4'd3, 8'h00, 9'h1FF);

    // Invalid selects from a clean counter, then saturation of the 2-bit counter.
    do_reset();
    cycle("inv", 1'b1, 4'd9, 8'h01, 9'h0);
    cycle("inv", 1'b1, 4'd12, 8'h02, 9'h0);
    cycle("inv", 1'b1, 4'd15, 8'h03, 9'h0);
    chk("inv.cnt3", drop_cnt, 8'd3);
    chk("inv.no_valid", out_valid, 9'h0);
    for (int i = 0; i < 2; i++) begin
      cycle("sat", 1'b1, 4'd13, 8'h00, 9'h0);
      chk("sat.pulse", drop_pulse_s, 1'b1);
      chk("sat.hold3", drop_cnt_s, 2'd3);
    end
    cycle("sat.nodrop", 1'b0, 4'd9, 8'h00, 9'h0);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cycle("rnd", 1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
            8'($urandom), 9'($urandom) | 9'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
